// File: rtl/dplca_pkg.sv
// Shared D-PLCA definitions: node FSM encodings, PLCA command codes and
// table geometry used by the TXOP claim table controller.
package dplca_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2
  } dplca_state_e;

  typedef enum logic [1:0] {
    CMD_BEACON = 2'b00,
    CMD_COMMIT = 2'b01,
    CMD_NONE   = 2'b10
  } plca_cmd_e;

  typedef enum logic {
    PLCA_STATUS_FAIL = 1'b0,
    PLCA_STATUS_OK   = 1'b1
  } plca_status_e;

  localparam logic [7:0] TO_ID_NONE    = 8'd255;
  localparam int         DPLCA_TABLE_W = 256;

endpackage

// File: rtl/dplca_claim_bitmap.sv
// Two-window TXOP claim storage: claims land in the current window, an age
// shift moves it to the previous window, and the registered table is their OR.
module dplca_claim_bitmap
  import dplca_pkg::*;
#(
  parameter int TABLE_W = DPLCA_TABLE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               set_en_i,
  input  logic [7:0]         set_id_i,
  input  logic               shift_i,
  output logic [TABLE_W-1:0] table_o
);

  logic [TABLE_W-1:0] cur_q, cur_d;
  logic [TABLE_W-1:0] prev_q, prev_d;
  logic [TABLE_W-1:0] table_q, table_d;
  logic [TABLE_W-1:0] set_mask;
  logic [TABLE_W-1:0] merged;

  // A claim arriving with a shift is merged first so it ages with the closing window.
  always_comb begin
    set_mask = '0;
    if (set_en_i) set_mask[set_id_i] = 1'b1;
    merged  = cur_q | set_mask;
    cur_d   = merged;
    prev_d  = prev_q;
    table_d = cur_q | prev_q;
    if (clear_i) begin
      cur_d   = '0;
      prev_d  = '0;
      table_d = '0;
    end else if (shift_i) begin
      prev_d = merged;
      cur_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_q   <= '0;
      prev_q  <= '0;
      table_q <= '0;
    end else begin
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      table_q <= table_d;
    end
  end

  assign table_o = table_q;

endmodule

// File: rtl/dplca_txop_table_ctrl.sv
// D-PLCA TXOP claim table controller: tracks PLCA cycles between beacons,
// records active TOs and paces table-update / new-age qualifiers.
module dplca_txop_table_ctrl
  import dplca_pkg::*;
#(
  parameter int AGE_CYCLES = 16,
  parameter int TABLE_W    = DPLCA_TABLE_W
) (
  input  logic               clk,
  input  logic               plca_reset_n,
  input  logic               dplca_aging,
  input  logic               beacon_strb,
  input  logic               to_end_strb,
  input  logic [7:0]         cur_id,
  input  logic               to_active,
  output logic [TABLE_W-1:0] txop_claim_table,
  output logic               dplca_txop_table_upd,
  output logic               dplca_new_age
);

  localparam logic [7:0] AGE_LAST = 8'(AGE_CYCLES - 1);

  dplca_state_e state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         upd_q, upd_d;
  logic         new_age_q, new_age_d;
  logic         clear, claim, shift;

  // Dropping the aging enable overrides everything and suppresses any pending pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    upd_d     = 1'b0;
    new_age_d = new_age_q;
    clear     = 1'b0;
    claim     = 1'b0;
    shift     = 1'b0;
    if (!dplca_aging) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      new_age_d = 1'b0;
      clear     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clear   = 1'b1;
          state_d = ST_SYNC;
        end
        ST_SYNC: begin
          if (beacon_strb) begin
            cnt_d   = '0;
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          claim = to_end_strb & to_active & (cur_id != TO_ID_NONE);
          if (beacon_strb) begin
            upd_d = 1'b1;
            if (cnt_q == AGE_LAST) begin
              shift     = 1'b1;
              cnt_d     = '0;
              new_age_d = 1'b1;
            end else begin
              cnt_d     = cnt_q + 8'd1;
              new_age_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!plca_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      upd_q     <= 1'b0;
      new_age_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      upd_q     <= upd_d;
      new_age_q <= new_age_d;
    end
  end

  dplca_claim_bitmap #(
    .TABLE_W(TABLE_W)
  ) u_bitmap (
    .clk     (clk),
    .rst_n   (plca_reset_n),
    .clear_i (clear),
    .set_en_i(claim),
    .set_id_i(cur_id),
    .shift_i (shift),
    .table_o (txop_claim_table)
  );

  assign dplca_txop_table_upd = upd_q;
  assign dplca_new_age        = new_age_q;

endmodule
